fsm_seq_ctrl: RTL
=================

Name: fsm_seq_ctrl

Overview:
- Sequencer and arbiter placed in front of the one-hot x/y sequence-detector FSM.
- Shares that FSM between two requesters, each offering a 2-bit {x,y} symbol on a valid/ready handshake.
- Drives one legal symbol at a time onto the FSM's x/y inputs, captures the resulting z, and returns it tagged with the requester id.
- Also owns the FSM's reset: power-on and on-demand flush.

Parameters:
- CNT_W, 8: width of the per-requester z-hit counters (saturating).
- FLUSH_CYC, 2: number of cycles fsm_rst is held high during a flush (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req0_valid  in  1  requester 0 has a symbol.
- req0_sym  in  2  requester 0 symbol {x,y}.
- req0_ready  out  1  requester 0 symbol accepted this cycle.
- req1_valid  in  1  requester 1 has a symbol.
- req1_sym  in  2  requester 1 symbol {x,y}.
- req1_ready  out  1  requester 1 symbol accepted this cycle.
- flush  in  1  request FSM reset plus counter clear.
- fsm_x  out  1  to FSM x.
- fsm_y  out  1  to FSM y.
- fsm_z  in  1  from FSM z (registered in the FSM).
- fsm_rst  out  1  to FSM rst, active-high.
- resp_valid  out  1  one-cycle pulse; resp_id/resp_z valid.
- resp_id  out  1  requester of this response.
- resp_z  out  1  captured z.
- err_sym  out  1  one-cycle pulse; illegal symbol (00/11) was accepted and dropped.
- err_id  out  1  requester that sent the illegal symbol.
- cnt0  out  CNT_W  count of z=1 responses to requester 0.
- cnt1  out  CNT_W  count of z=1 responses to requester 1.
- busy  out  1  state != IDLE.

Behaviour:
- State machine, one-hot, four states:
  - IDLE: arbitrates.
  - DRIVE: 1 cycle; fsm_x/fsm_y = latched symbol.
  - CAPT: 1 cycle; fsm_x/fsm_y = 00; fsm_z sampled.
  - FLUSH: FLUSH_CYC cycles.
- Reset (rst==0 at a clock edge):
  - state = IDLE; round-robin pointer = requester 0.
  - All registered outputs 0: resp_*, err_*, cnt0, cnt1.
  - fsm_rst = 1 combinationally while rst==0, so the FSM returns to S0 with it.
  - Reset mid-operation aborts any in-flight symbol; no response is emitted.
- fsm_x/fsm_y are 00 in every state except DRIVE. The FSM holds state on 00.
- IDLE arbitration:
  - flush has priority over requests. If flush==1, no ready is asserted and the next state is FLUSH.
  - Otherwise, round-robin: the pointer names the preferred requester. If only one valid is high, that requester wins.
  - The winner's ready=1 combinationally in the same cycle. At most one ready is high per cycle, and ready is 0 in every non-IDLE state.
  - After any acceptance the pointer moves to the other requester.
- Accepted symbol 10 or 01: latch symbol and id; next state DRIVE.
- Accepted symbol 00 or 11:
  - Dropped; err_sym=1 and err_id=id on the next cycle; state stays IDLE.
  - The pointer still advances.
  - No FSM activity and no resp.
- Response timing:
  - Acceptance in cycle T, DRIVE in T+1. The FSM updates z at the end of T+1.
  - CAPT in T+2 samples fsm_z.
  - resp_valid=1 in T+3 with resp_id and resp_z, and the state is back in IDLE in T+3.
  - Maximum throughput is one symbol per 3 cycles.
- Counters: in CAPT, if fsm_z==1, increment cnt[id] (visible in T+3). Counters saturate at 2^CNT_W-1 and never wrap.
- flush:
  - Sampled only in IDLE. If asserted during DRIVE/CAPT it must be held by the requester; the in-flight symbol completes first.
  - FLUSH: fsm_rst=1 for exactly FLUSH_CYC cycles, then IDLE.
  - On FLUSH entry: cnt0 and cnt1 cleared, pointer reset to requester 0.
  - If flush is still high on return to IDLE, another FLUSH begins.
- Back-to-back: an IDLE cycle may accept a new symbol in the same cycle resp_valid pulses for the previous one.

Test Plan:
- Reset then req0 only, symbols 01,10,10 → fsm_x/y pulses 01,10,10 on DRIVE cycles only; resp_z = 1,0,0; cnt0=1; resp_valid exactly 3 cycles after each ready.
- Both valid continuously, req0 sends 10 and req1 sends 01 repeatedly → grants alternate 0,1,0,1 starting at 0; FSM path S0→S2→S3→S1→S3 gives resp_z 0,1,1,0.
- req1 sends 11, then 00 → ready pulses, err_sym=1 with err_id=1 each time one cycle later; fsm_x/y stay 00; no resp_valid; the pointer still advances (a concurrent req0 wins next).
- flush asserted during DRIVE → the symbol completes with resp_valid; then fsm_rst=1 for FLUSH_CYC=2 cycles; cnt0=cnt1=0; the next symbol 01 yields z=1 (FSM back in S0).
- CNT_W=2, 5 consecutive z=1 responses for req0 → cnt0 sticks at 3.
- rst driven low during CAPT → next cycle busy=0, all outputs 0, fsm_rst=1 while rst low, no resp_valid for the aborted symbol.

Source files
------------

// File: rtl/fsm_seq_ctrl.sv
// Two-requester sequencer/arbiter in front of the one-hot x/y sequence detector.
// Feeds one legal symbol at a time to the detector, returns its z tagged with the requester id.
module fsm_seq_ctrl #(
    parameter int CNT_W     = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_sym,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_sym,
    output logic             req1_ready,
    input  logic             flush,
    output logic             fsm_x,
    output logic             fsm_y,
    input  logic             fsm_z,
    output logic             fsm_rst,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_z,
    output logic             err_sym,
    output logic             err_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic             busy
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_DRIVE = 4'b0010,
        ST_CAPT  = 4'b0100,
        ST_FLUSH = 4'b1000
    } state_t;

    localparam int               FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ptr;
    logic [1:0]       r_sym;
    logic             r_id;
    logic [FC_W-1:0]  r_flush_cnt;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic             r_resp_z;
    logic             r_err_sym;
    logic             r_err_id;
    logic [CNT_W-1:0] r_cnt [2];

    logic             w_accept;
    logic             w_gid;
    logic [1:0]       w_gsym;
    logic             w_legal;
    logic             w_flush_start;

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_gid         = 1'b0;
        w_gsym        = 2'b00;
        w_flush_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_flush_start = 1'b1;
                    w_state_next  = ST_FLUSH;
                end else if (req0_valid || req1_valid) begin
                    w_accept     = 1'b1;
                    // Pointer only matters on contention; a lone requester always wins.
                    w_gid        = (req0_valid && req1_valid) ? r_ptr : req1_valid;
                    w_gsym       = w_gid ? req1_sym : req0_sym;
                    if (w_gsym[1] ^ w_gsym[0]) begin
                        w_state_next = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: w_state_next = ST_CAPT;
            ST_CAPT:  w_state_next = ST_IDLE;
            ST_FLUSH: begin
                if (r_flush_cnt == FC_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    assign w_legal    = w_gsym[1] ^ w_gsym[0];
    assign req0_ready = rst && w_accept && !w_gid;
    assign req1_ready = rst && w_accept && w_gid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_sym        <= 2'b00;
            r_id         <= 1'b0;
            r_flush_cnt  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_z     <= 1'b0;
            r_err_sym    <= 1'b0;
            r_err_id     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= (r_state == ST_CAPT);
            r_err_sym    <= w_accept && !w_legal;
            if (w_accept) begin
                r_ptr    <= ~w_gid;
                r_id     <= w_gid;
                r_sym    <= w_gsym;
                r_err_id <= w_gid;
            end
            if (w_flush_start) begin
                r_ptr       <= 1'b0;
                r_flush_cnt <= '0;
            end else if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (r_state == ST_CAPT) begin
                r_resp_id <= r_id;
                r_resp_z  <= fsm_z;
            end
        end
    end

    // Per-requester saturating z-hit counters, cleared when a flush begins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt[gi] <= '0;
                end else if (w_flush_start) begin
                    r_cnt[gi] <= '0;
                end else if ((r_state == ST_CAPT) && fsm_z && (r_id == 1'(gi))
                             && (r_cnt[gi] != CNT_MAX)) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign fsm_x      = (r_state == ST_DRIVE) ? r_sym[1] : 1'b0;
    assign fsm_y      = (r_state == ST_DRIVE) ? r_sym[0] : 1'b0;
    assign fsm_rst    = !rst || (r_state == ST_FLUSH);
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_z     = r_resp_z;
    assign err_sym    = r_err_sym;
    assign err_id     = r_err_id;
    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];

endmodule
